// File: rtl/comb_response_checker.sv
// comb_response_checker
// Observes a stimulus sweep over every N_IN-bit input vector and collects the
// outputs of a reference (a) and a candidate (b) implementation. It builds both
// truth tables, tracks which vectors have been seen, counts the vectors where
// a and b differ, remembers the first one, and flags repeated vectors whose
// outputs differ from the first capture. Once every vector has been seen,
// collection closes and a single pass/fail verdict is held until clear or rst.
module comb_response_checker #(
  parameter int  N_IN = 3,
  localparam int T    = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  input  logic            in_f_a,
  input  logic            in_f_b,
  output logic [T-1:0]    tt_a,
  output logic [T-1:0]    tt_b,
  output logic [T-1:0]    seen,
  output logic [N_IN:0]   mismatch_cnt,
  output logic            first_err_vld,
  output logic [N_IN-1:0] first_err_vec,
  output logic            conflict,
  output logic            done,
  output logic            pass
);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  state_t          state_q;
  logic [T-1:0]    tt_a_q;
  logic [T-1:0]    tt_b_q;
  logic [T-1:0]    seen_q;
  logic [N_IN:0]   mismatch_cnt_q;
  logic            first_err_vld_q;
  logic [N_IN-1:0] first_err_vec_q;
  logic            conflict_q;
  logic            done_q;
  logic            pass_q;

  logic            accept;
  logic            is_new;
  logic            pair_diff;
  logic            repeat_diff;
  logic [T-1:0]    seen_d;
  logic [N_IN:0]   mismatch_cnt_d;

  // clear outranks a sample in the same cycle; DONE refuses samples entirely
  assign in_ready    = (state_q == COLLECT);
  assign accept      = in_valid && in_ready && !clear;
  assign is_new      = !seen_q[in_vec];
  assign pair_diff   = (in_f_a != in_f_b);
  assign repeat_diff = (in_f_a != tt_a_q[in_vec]) || (in_f_b != tt_b_q[in_vec]);

  // Post-update coverage and count, so the closing edge can decide done/pass
  always_comb begin
    seen_d         = seen_q;
    seen_d[in_vec] = 1'b1;
    mismatch_cnt_d = mismatch_cnt_q;
    if (pair_diff) begin
      mismatch_cnt_d = mismatch_cnt_q + {{N_IN{1'b0}}, 1'b1};
    end
  end

  // Collection state machine with all result registers
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q         <= COLLECT;
      tt_a_q          <= '0;
      tt_b_q          <= '0;
      seen_q          <= '0;
      mismatch_cnt_q  <= '0;
      first_err_vld_q <= 1'b0;
      first_err_vec_q <= '0;
      conflict_q      <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else if (accept) begin
      if (is_new) begin
        seen_q[in_vec] <= 1'b1;
        tt_a_q[in_vec] <= in_f_a;
        tt_b_q[in_vec] <= in_f_b;
        mismatch_cnt_q <= mismatch_cnt_d;
        if (pair_diff && !first_err_vld_q) begin
          first_err_vld_q <= 1'b1;
          first_err_vec_q <= in_vec;
        end
        // A repeat can never complete coverage, so conflict_q is final here
        if (&seen_d) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          pass_q  <= (mismatch_cnt_d == '0) && !conflict_q;
        end
      end else if (repeat_diff) begin
        conflict_q <= 1'b1;
      end
    end
  end

  assign tt_a          = tt_a_q;
  assign tt_b          = tt_b_q;
  assign seen          = seen_q;
  assign mismatch_cnt  = mismatch_cnt_q;
  assign first_err_vld = first_err_vld_q;
  assign first_err_vec = first_err_vec_q;
  assign conflict      = conflict_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: doc/comb_response_checker.md
# comb_response_checker

- Sequential response checker for exhaustive testing of small combinational blocks.
- Accepts one response sample per handshake: an input vector plus the outputs of two implementations (reference and candidate) for that vector.
- Accumulates both truth tables, tracks vector coverage, counts and locates mismatches, and flags inconsistent repeats.
- Sits on the observation side of a stimulus sweep and reports a single pass/fail once every vector has been seen.

## Interface

Parameters:
- N_IN, 3, number of inputs of the checked function; table depth T = 2**N_IN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous restart of collection; same effect as rst.
- in_valid  in  1  sample present this cycle.
- in_ready  out  1  block accepts samples; high only in COLLECT.
- in_vec  in  N_IN  input vector, {x,y,z} order with x as MSB.
- in_f_a  in  1  reference implementation output for in_vec.
- in_f_b  in  1  candidate implementation output for in_vec.
- tt_a  out  T  captured reference truth table; bit v is the output for vector v.
- tt_b  out  T  captured candidate truth table.
- seen  out  T  coverage; bit v is set once vector v has been accepted.
- mismatch_cnt  out  N_IN+1  number of distinct vectors where a != b.
- first_err_vld  out  1  a mismatch has been recorded.
- first_err_vec  out  N_IN  vector of the first recorded mismatch.
- conflict  out  1  sticky; a repeated vector returned a different a or b than first captured.
- done  out  1  all T vectors are covered; collection is closed.
- pass  out  1  meaningful only when done; equals (mismatch_cnt==0) && !conflict.

## Operation

- States: COLLECT and DONE.
- Reset (rst, or clear): state goes to COLLECT, and all outputs clear to 0: tt_a, tt_b, seen, mismatch_cnt, first_err_vld, first_err_vec, conflict, done, pass. in_ready is 1 after reset.
- Accept condition: in_valid && in_ready && !clear.
- Accept of a new vector v (seen[v]==0):
  - seen[v]<=1; tt_a[v]<=in_f_a; tt_b[v]<=in_f_b.
  - If in_f_a!=in_f_b: mismatch_cnt increments. If first_err_vld==0, first_err_vec<=v and first_err_vld<=1.
- Accept of a repeated vector (seen[v]==1):
  - Tables, seen and mismatch_cnt are unchanged.
  - If in_f_a!=tt_a[v] or in_f_b!=tt_b[v], conflict<=1.
- COLLECT -> DONE on the same edge that sets the last clear bit of seen. done<=1 and pass is computed from the post-update count and conflict flag.
- In DONE:
  - in_ready=0 and in_valid is ignored; all outputs hold.
  - The only exit is clear or rst, which goes back to COLLECT.
- clear has priority over a simultaneous in_valid; that sample is discarded.
- mismatch_cnt cannot exceed T, because each vector is counted at most once, so no saturation is needed.

## Timing

- All outputs except in_ready are registered. in_ready is decoded from the state register.
- A sample accepted at edge k is reflected in all outputs after edge k.
- done, pass and in_ready=0 become visible in the cycle after the final new vector is accepted.
- Throughput is one sample per cycle in COLLECT, with no backpressure other than DONE.
- Reset or clear asserted mid-collection: all partial results are discarded at that edge, and collection restarts empty in the next cycle.

## Test plan

- Sweep v=0..7 with in_f_a=in_f_b=v[0] -> after the 8th sample, seen=8'hFF, tt_a=tt_b=8'hAA, mismatch_cnt=0, done=1, pass=1, in_ready=0.
- Sweep 0..7 with in_f_b inverted only at v=3 and v=6 -> mismatch_cnt=2, first_err_vld=1, first_err_vec=3, pass=0.
- Send v=5 with (a,b)=(1,1), then v=5 again with (1,0), then the remaining vectors all matching -> conflict=1, mismatch_cnt=0, tt_b[5]=1, pass=0.
- After done, drive in_valid with v=2 and a mismatching pair -> all outputs unchanged. Then pulse clear with in_valid high -> every output reads 0 and in_ready=1 the next cycle, and the sample is not captured.
- Accept 4 vectors, then assert rst for one cycle -> seen=0 and mismatch_cnt=0. A fresh full sweep then completes with done after exactly 8 accepts.
- Gap cycles (in_valid=0) between samples, out-of-order sweep 7,0,3,1,6,2,5,4 -> same final tables as the in-order sweep, and done in the cycle after vector 4 is accepted.
